preamble_correlator: RTL and testbench

Parametrised 1-bit sliding cross-correlator that finds the BPSK preamble in the hard-limited receive sample stream. It generates the reference template internally and detects either carrier polarity. A peak search over one full wavelength picks the best sample phase, and the block then holds a lock until it is cleared. It sits between the receive sampler and the demodulator. It supplies `phase` and `polarity` for symbol alignment.

---
 rtl/preamble_correlator.sv | 142 ++++++++++++++
 tb/tb_preamble_correlator.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/preamble_correlator.sv
// preamble_correlator: sliding 1-bit correlator with polarity folding, one-wavelength peak search and lock
module preamble_correlator #(
  parameter int PREAMBLE_LENGTH = 8,
  parameter int WAVELENGTH = 8,
  parameter logic [PREAMBLE_LENGTH-1:0] PREAMBLE = 8'b10110010,
  parameter int THRESHOLD = 0,
  localparam int SAMPLE_COUNT = PREAMBLE_LENGTH * WAVELENGTH,
  localparam int SW = $clog2(SAMPLE_COUNT + 1),
  localparam int PW = $clog2(WAVELENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          sample_valid,
  input  logic          sample,
  output logic          detected,
  output logic          locked,
  output logic [PW-1:0] phase,
  output logic [SW-1:0] score,
  output logic          polarity
);
  localparam int WW = $clog2(WAVELENGTH + 1);
  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] PEAK = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  function automatic logic [SAMPLE_COUNT-1:0] make_template();
    logic [SAMPLE_COUNT-1:0] t;
    t = '0;
    for (int k = 0; k < SAMPLE_COUNT; k++)
      t[SAMPLE_COUNT-1-k] = PREAMBLE[PREAMBLE_LENGTH-1-k/WAVELENGTH] ^ ((k % WAVELENGTH) >= WAVELENGTH / 2);
    return t;
  endfunction
  localparam logic [SAMPLE_COUNT-1:0] TEMPLATE = make_template();
  logic [SAMPLE_COUNT-1:0] hist_q, hist_d;
  logic [SW-1:0] fill_q, fill_d, dist_q, dist_d, best_f_q, best_f_d, score_q, score_d;
  logic [PW-1:0] ph_q, ph_d, tag_q, tag_d, dtag_q, dtag_d, best_t_q, best_t_d, phase_q, phase_d;
  logic acc_q, acc_d, dv_q, dv_d, best_p_q, best_p_d, det_q, det_d, pol_q, pol_d;
  logic [1:0] state_q, state_d;
  logic [WW-1:0] win_q, win_d;
  logic [SW-1:0] inv, fold;
  logic fpol, better;
  always_comb begin
    hist_d = sample_valid ? {hist_q[SAMPLE_COUNT-2:0], sample} : hist_q;
    fill_d = (sample_valid && fill_q != SW'(SAMPLE_COUNT)) ? fill_q + 1'b1 : fill_q;
    ph_d = sample_valid ? ((ph_q == PW'(WAVELENGTH - 1)) ? '0 : ph_q + 1'b1) : ph_q;
    acc_d = sample_valid;
    tag_d = ph_q;
    dv_d = acc_q && fill_q == SW'(SAMPLE_COUNT);
    dtag_d = tag_q;
    dist_d = '0;
    for (int i = 0; i < SAMPLE_COUNT; i++)
      dist_d = dist_d + SW'(hist_q[i] ^ TEMPLATE[i]);
  end
  // Fold the raw distance so the inverted carrier scores as well as the upright one
  always_comb begin
    inv = SW'(SAMPLE_COUNT) - dist_q;
    fpol = inv < dist_q;
    fold = fpol ? inv : dist_q;
    better = fold < best_f_q;
    state_d = state_q;
    win_d = win_q;
    best_f_d = best_f_q;
    best_p_d = best_p_q;
    best_t_d = best_t_q;
    det_d = 1'b0;
    phase_d = phase_q;
    score_d = score_q;
    pol_d = pol_q;
    if (clear) begin
      state_d = SEARCH;
      win_d = '0;
      best_f_d = '0;
      best_p_d = 1'b0;
      best_t_d = '0;
      phase_d = '0;
      score_d = '0;
      pol_d = 1'b0;
    end else if (dv_q && state_q == SEARCH && fold <= SW'(THRESHOLD)) begin
      state_d = PEAK;
      win_d = WW'(1);
      best_f_d = fold;
      best_p_d = fpol;
      best_t_d = dtag_q;
    end else if (dv_q && state_q == PEAK) begin
      best_f_d = better ? fold : best_f_q;
      best_p_d = better ? fpol : best_p_q;
      best_t_d = better ? dtag_q : best_t_q;
      win_d = win_q + 1'b1;
      if (win_d == WW'(WAVELENGTH)) begin
        state_d = LOCKED;
        det_d = 1'b1;
        phase_d = best_t_d;
        score_d = best_f_d;
        pol_d = best_p_d;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      ph_q <= '0;
      acc_q <= 1'b0;
      tag_q <= '0;
      dv_q <= 1'b0;
      dist_q <= '0;
      dtag_q <= '0;
      state_q <= SEARCH;
      win_q <= '0;
      best_f_q <= '0;
      best_p_q <= 1'b0;
      best_t_q <= '0;
      det_q <= 1'b0;
      phase_q <= '0;
      score_q <= '0;
      pol_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      ph_q <= ph_d;
      acc_q <= acc_d;
      tag_q <= tag_d;
      dv_q <= dv_d;
      dist_q <= dist_d;
      dtag_q <= dtag_d;
      state_q <= state_d;
      win_q <= win_d;
      best_f_q <= best_f_d;
      best_p_q <= best_p_d;
      best_t_q <= best_t_d;
      det_q <= det_d;
      phase_q <= phase_d;
      score_q <= score_d;
      pol_q <= pol_d;
    end
  end
  assign detected = det_q;
  assign locked = state_q == LOCKED;
  assign phase = phase_q;
  assign score = score_q;
  assign polarity = pol_q;
endmodule

// File: tb/tb_preamble_correlator.sv
// tb_preamble_correlator: directed and random stimulus against an event-queue reference model
module tb_preamble_correlator;
  localparam int PL = 4;
  localparam int WL = 8;
  localparam int SC = 32;
  localparam int TH = 2;
  localparam logic [3:0] PRE = 4'b1011;
  logic clk = 1'b0;
  logic reset = 1'b0, clear = 1'b0, sample_valid = 1'b0, sample = 1'b0;
  logic detected, locked, polarity;
  logic [2:0] phase;
  logic [5:0] score;
  always #5 clk = ~clk;
  preamble_correlator #(
    .PREAMBLE_LENGTH(PL), .WAVELENGTH(WL), .PREAMBLE(PRE), .THRESHOLD(TH)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .sample_valid(sample_valid), .sample(sample),
    .detected(detected), .locked(locked), .phase(phase), .score(score), .polarity(polarity)
  );
  typedef struct {int due; int f; bit p; int tag;} ev_t;
  ev_t evq[$];
  bit hist[$];
  int vectors = 0, miscompares = 0;
  int edge_cnt = 0, acc_cnt = 0, pulses = 0, m_cnt = 0;
  bit m_peak = 0, m_locked = 0, m_det = 0, m_pol = 0, bp = 0;
  int m_phase = 0, m_score = 0, bf = 0, bt = 0;
  function automatic bit tmpl(input int k);
    logic [3:0] p;
    bit b;
    p = PRE;
    b = p[PL-1-k/WL];
    return ((k % WL) < WL / 2) ? b : !b;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, got, exp, edge_cnt);
    end
  endtask
  task automatic model_edge(input bit r, input bit c, input bit v, input bit s);
    ev_t e;
    bit has;
    int d;
    edge_cnt++;
    m_det = 0;
    if (r) begin
      hist.delete(); evq.delete(); acc_cnt = 0;
      m_peak = 0; m_locked = 0; m_phase = 0; m_score = 0; m_pol = 0;
      return;
    end
    has = 0;
    if (evq.size() > 0 && evq[0].due == edge_cnt) begin
      e = evq.pop_front();
      has = 1;
    end
    if (c) begin
      m_peak = 0; m_locked = 0; m_phase = 0; m_score = 0; m_pol = 0;
    end else if (has && !m_locked) begin
      if (!m_peak) begin
        if (e.f <= TH) begin m_peak = 1; m_cnt = 1; bf = e.f; bp = e.p; bt = e.tag; end
      end else begin
        if (e.f < bf) begin bf = e.f; bp = e.p; bt = e.tag; end
        m_cnt++;
        if (m_cnt == WL) begin
          m_peak = 0; m_locked = 1; m_det = 1;
          m_phase = bt; m_score = bf; m_pol = bp;
        end
      end
    end
    if (v) begin
      hist.push_back(s);
      if (hist.size() > SC) hist.delete(0);
      if (hist.size() == SC) begin
        d = 0;
        for (int k = 0; k < SC; k++) d += (hist[k] != tmpl(k)) ? 1 : 0;
        e.due = edge_cnt + 2;
        e.p = (SC - d) < d;
        e.f = e.p ? SC - d : d;
        e.tag = acc_cnt % WL;
        evq.push_back(e);
      end
      acc_cnt++;
    end
  endtask
  task automatic step(input bit r, input bit c, input bit v, input bit s);
    reset = r; clear = c; sample_valid = v; sample = s;
    @(posedge clk);
    model_edge(r, c, v, s);
    #1;
    if (detected === 1'b1) pulses++;
    chk("detected", detected, m_det);
    chk("locked", locked, m_locked);
    chk("phase", phase, m_phase);
    chk("score", score, m_score);
    chk("polarity", polarity, m_pol);
  endtask
  task automatic zeros(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) step(0, 0, 0, 1'($urandom));
      step(0, 0, 1, 0);
    end
  endtask
  task automatic send_template(input bit inv, input int fa, input int fb, input bit gaps);
    for (int k = 0; k < SC; k++) begin
      if (gaps) step(0, 0, 0, 1'($urandom));
      step(0, 0, 1, tmpl(k) ^ inv ^ (k == fa || k == fb));
    end
  endtask
  int p0;
  initial begin
    step(1, 0, 0, 0);
    chk("reset_locked", locked, 0);
    chk("reset_phase", phase, 0);
    zeros(200, 0);
    chk("s1_pulses", pulses, 0);
    chk("s1_locked", locked, 0);
    step(1, 0, 0, 0); p0 = pulses;
    zeros(43, 0); send_template(0, -1, -1, 0); zeros(12, 0);
    chk("s2_pulses", pulses - p0, 1);
    chk("s2_phase", phase, 2);
    chk("s2_score", score, 0);
    chk("s2_polarity", polarity, 0);
    chk("s2_locked", locked, 1);
    step(1, 0, 0, 0); p0 = pulses;
    zeros(43, 0); send_template(1, -1, -1, 0); zeros(12, 0);
    chk("s3_pulses", pulses - p0, 1);
    chk("s3_polarity", polarity, 1);
    chk("s3_score", score, 0);
    chk("s3_phase", phase, 2);
    step(1, 0, 0, 0); p0 = pulses;
    zeros(43, 1); send_template(0, 1, 2, 1); zeros(12, 1);
    chk("s4_pulses", pulses - p0, 1);
    chk("s4_score", score, 2);
    chk("s4_phase", phase, 2);
    step(1, 0, 0, 0);
    zeros(43, 0); send_template(0, -1, -1, 0); zeros(3, 0);
    step(1, 0, 0, 0); p0 = pulses;
    send_template(0, -1, -1, 0);
    chk("s5_early", pulses - p0, 0);
    zeros(12, 0);
    chk("s5_pulses", pulses - p0, 1);
    chk("s5_phase", phase, 7);
    zeros(30, 0);
    step(0, 1, 0, 0);
    chk("s6_unlock", locked, 0);
    chk("s6_score_zero", score, 0);
    p0 = pulses;
    zeros(5, 0); send_template(0, -1, -1, 0); zeros(12, 0);
    chk("s6_pulses", pulses - p0, 1);
    chk("s6_phase", phase, (32 + 12 + 30 + 5 + 32 - 1) % 8);
    zeros(20, 0); step(0, 1, 0, 0); p0 = pulses;
    zeros(20, 0); send_template(0, -1, -1, 0); zeros(3, 0);
    step(0, 1, 1, 0); zeros(20, 0);
    chk("s7_no_relock", pulses - p0, 0);
    chk("s7_locked", locked, 0);
    step(1, 0, 0, 0);
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 100; i++)
        step(0, ($urandom % 64) == 0, ($urandom % 4) != 0, 1'($urandom));
      send_template(1'($urandom), $urandom % 32, $urandom % 32, 1'($urandom));
      zeros(10, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
